// File: rtl/xbus_dma_master.sv
// X-bus DMA master: copies LEN 32-bit words from SRC to DST, issuing one read
// and then one write transaction per word over the XDREQ/XRD/XWR/XDACK handshake.
// Each request state is preceded by a gap state, so XDREQ is low for at least
// one cycle between transactions. HLT stretches the gap states only.
// All outputs come straight from flops.
//
// Optional feature: define XBUS_TIMEOUT_EN to abort a request that sees no
// XDACK within TMO_CYCLES cycles. The abort sets the sticky ERR flag and ends
// the copy with a DONE pulse. Without the macro, a request waits indefinitely
// for XDACK and ERR is tied low.

module xbus_dma_master #(
  parameter int unsigned LENW       = 16,
  parameter int unsigned TMO_CYCLES = 255
) (
  input  logic            CLK,
  input  logic            RES,
  input  logic            HLT,
  input  logic            START,
  input  logic [31:0]     SRC,
  input  logic [31:0]     DST,
  input  logic [LENW-1:0] LEN,
  output logic            BUSY,
  output logic            DONE,
  output logic            ERR,
  output logic [LENW-1:0] COUNT,
  output logic            XDREQ,
  output logic            XRD,
  output logic            XWR,
  output logic [3:0]      XBE,
  output logic [31:0]     XADDR,
  output logic [31:0]     XATAO,
  input  logic [31:0]     XATAI,
  input  logic            XDACK
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StRgap = 3'd1;
  localparam logic [2:0] StRreq = 3'd2;
  localparam logic [2:0] StWgap = 3'd3;
  localparam logic [2:0] StWreq = 3'd4;
  localparam logic [2:0] StFin  = 3'd5;

  // A zero timeout would abort every request before the responder could answer.
  if (TMO_CYCLES == 0) begin : g_bad_tmo
    $error("TMO_CYCLES must be nonzero");
  end

  logic [2:0]      state_q, state_d;
  logic [31:0]     src_q, src_d;
  logic [31:0]     dst_q, dst_d;
  logic [31:0]     buf_q, buf_d;
  logic [LENW-1:0] count_q, count_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            xdreq_q, xdreq_d;
  logic            xrd_q, xrd_d;
  logic            xwr_q, xwr_d;
  logic [3:0]      xbe_q, xbe_d;
  logic [31:0]     xaddr_q, xaddr_d;
  logic [31:0]     xatao_q, xatao_d;

`ifdef XBUS_TIMEOUT_EN
  localparam int unsigned TmoW =
      ($clog2(TMO_CYCLES + 1) > 8) ? $clog2(TMO_CYCLES + 1) : 8;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TMO_CYCLES - 1);

  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            err_q, err_d;
  logic            tmo_hit;

  // The abort fires on the edge where the counter would reach TMO_CYCLES.
  assign tmo_hit = (tmo_q == TmoLast);
`endif

  // Next-state logic for the copy sequencer and its registered outputs.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    buf_d   = buf_q;
    count_d = count_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef XBUS_TIMEOUT_EN
    err_d   = err_q;
    tmo_d   = '0;
`endif

    case (state_q)
      StIdle: begin
        if (START) begin
          src_d   = SRC & 32'hFFFF_FFFC;
          dst_d   = DST & 32'hFFFF_FFFC;
          count_d = LEN;
          busy_d  = 1'b1;
`ifdef XBUS_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = (LEN == '0) ? StFin : StRgap;
        end
      end

      StRgap: begin
        if (!HLT) state_d = StRreq;
      end

      StRreq: begin
        if (XDACK) begin
          buf_d   = XATAI;
          state_d = StWgap;
        end
`ifdef XBUS_TIMEOUT_EN
        else if (tmo_hit) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StFin;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end

      StWgap: begin
        if (!HLT) state_d = StWreq;
      end

      StWreq: begin
        if (XDACK) begin
          src_d   = src_q + 32'd4;
          dst_d   = dst_q + 32'd4;
          count_d = count_q - 1'b1;
          if (count_q == LENW'(1)) begin
            // Last word: DONE rises together with the entry into FIN.
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StFin;
          end else begin
            state_d = StRgap;
          end
        end
`ifdef XBUS_TIMEOUT_EN
        else if (tmo_hit) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StFin;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end

      StFin: begin
        // Bus exits arrive with DONE already pulsing; a zero-length copy
        // issues its pulse here, one cycle after BUSY rose.
        if (done_q) begin
          state_d = StIdle;
        end else begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end

      default: state_d = StIdle;
    endcase

    xdreq_d = (state_d == StRreq) || (state_d == StWreq);
    xrd_d   = (state_d == StRreq);
    xwr_d   = (state_d == StWreq);
    xbe_d   = xdreq_d ? 4'hF : 4'h0;
    xaddr_d = xrd_d ? src_d : (xwr_d ? dst_d : 32'h0);
    xatao_d = xwr_d ? buf_d : 32'h0;
  end

  // State, address/data registers and output flops.
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      buf_q   <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      xdreq_q <= 1'b0;
      xrd_q   <= 1'b0;
      xwr_q   <= 1'b0;
      xbe_q   <= '0;
      xaddr_q <= '0;
      xatao_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      buf_q   <= buf_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      xdreq_q <= xdreq_d;
      xrd_q   <= xrd_d;
      xwr_q   <= xwr_d;
      xbe_q   <= xbe_d;
      xaddr_q <= xaddr_d;
      xatao_q <= xatao_d;
    end
  end

`ifdef XBUS_TIMEOUT_EN
  // Acknowledge timeout counter and sticky error flag.
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign COUNT = count_q;
  assign XDREQ = xdreq_q;
  assign XRD   = xrd_q;
  assign XWR   = xwr_q;
  assign XBE   = xbe_q;
  assign XADDR = xaddr_q;
  assign XATAO = xatao_q;

endmodule

// File: tb/tb_xbus_dma_master.sv
// Self-checking bench for xbus_dma_master: a table of copy jobs, each run
// against a responder with programmable read/write wait and HLT window, plus
// hand sequences for reset during a write and (with XBUS_TIMEOUT_EN) timeout.
// Cycle 0 is the cycle START is driven; DONE/first-write cycles count from it.

module tb_xbus_dma_master;
  localparam int LENW = 16;

  logic            CLK = 1'b0;
  logic            RES, HLT, START, XDACK;
  logic [31:0]     SRC, DST, XATAI;
  logic [LENW-1:0] LEN;
  logic            BUSY, DONE, ERR, XDREQ, XRD, XWR;
  logic [3:0]      XBE;
  logic [31:0]     XADDR, XATAO;
  logic [LENW-1:0] COUNT;

  always #5 CLK = ~CLK;

  xbus_dma_master #(.LENW(LENW), .TMO_CYCLES(8)) dut (
    .CLK(CLK), .RES(RES), .HLT(HLT), .START(START), .SRC(SRC), .DST(DST), .LEN(LEN),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .COUNT(COUNT), .XDREQ(XDREQ), .XRD(XRD),
    .XWR(XWR), .XBE(XBE), .XADDR(XADDR), .XATAO(XATAO), .XATAI(XATAI), .XDACK(XDACK)
  );

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    int          len;
    int          rw;        // read wait (cycles from XDREQ rise to XDACK)
    int          ww;        // write wait
    int          hf;        // first cycle HLT is high
    int          hl;        // number of HLT cycles
    int          restart;   // cycle of a stray START pulse (0 = none)
    bit          junk;      // drive XDACK high whenever XDREQ is low
    int          exp_done;  // cycle DONE is high
    int          exp_fw;    // first cycle XWR is high (-1 = never)
  } vec_t;

  vec_t vecs[7];

  int errors = 0;
  int checks = 0;

  int cyc, rd_wait, wr_wait, hlt_from, hlt_len, age, proto_err;
  int first_wr, busy_cnt, done_cyc, done_cnt, req_cnt, err_c1;
  bit no_ack, junk, prev_req, prev_ack;
  logic [31:0] rd_log[$];
  logic [31:0] wa_log[$];
  logic [31:0] wd_log[$];

  function automatic logic [31:0] rdata(input logic [31:0] a);
    return a ^ 32'h5A3C_96E1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: sample DUT at posedge+1, drive HLT and responder for that cycle.
  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
    if (prev_ack && XDREQ) proto_err++;
    if (XRD && XWR) proto_err++;
    if ((XRD || XWR) != XDREQ) proto_err++;
    if (XBE !== (XDREQ ? 4'hF : 4'h0)) proto_err++;
    if (DONE && BUSY) proto_err++;
    if (BUSY) busy_cnt++;
    if (XDREQ) req_cnt++;
    if (DONE) begin
      done_cnt++;
      if (done_cyc < 0) done_cyc = cyc;
    end
    if (XWR && first_wr < 0) first_wr = cyc;
    HLT = (cyc >= hlt_from) && (cyc < hlt_from + hlt_len);
    if (XDREQ) begin
      age   = prev_req ? age + 1 : 0;
      XDACK = !no_ack && (age == (XRD ? rd_wait : wr_wait));
      XATAI = XRD ? rdata(XADDR) : 32'h0;
      if (XDACK) begin
        if (XRD) rd_log.push_back(XADDR);
        else begin
          wa_log.push_back(XADDR);
          wd_log.push_back(XATAO);
        end
      end
    end else begin
      XDACK = junk;
      XATAI = 32'hBAD0_BAD0;
    end
    prev_req = XDREQ;
    prev_ack = XDACK && XDREQ;
  endtask

  // Drives START in cycle 0, advances to cycle 1 and scrambles the config inputs.
  task automatic begin_job(input vec_t v, input bit noack);
    rd_log.delete(); wa_log.delete(); wd_log.delete();
    cyc = 0; first_wr = -1; done_cyc = -1; done_cnt = 0; busy_cnt = 0;
    req_cnt = 0; proto_err = 0;
    rd_wait = v.rw; wr_wait = v.ww; hlt_from = v.hf; hlt_len = v.hl;
    no_ack = noack; junk = v.junk;
    SRC = v.src; DST = v.dst; LEN = v.len[LENW-1:0]; START = 1'b1;
    HLT = (0 >= v.hf) && (0 < v.hf + v.hl);
    step();
    err_c1 = int'(ERR);
    START = 1'b0; SRC = 32'hDEAD_BEEF; DST = 32'hCAFE_F00D; LEN = '1;
  endtask

  task automatic run_job(input vec_t v, input string tag);
    logic [31:0] ea;
    begin_job(v, 1'b0);
    check({tag, " BUSY@1"}, BUSY, 1);
    check({tag, " ERR cleared by START"}, err_c1, 0);
    while (done_cyc < 0 && cyc < 200) begin
      START = (v.restart != 0) && (cyc == v.restart);
      step();
    end
    START = 1'b0;
    step();
    step();
    check({tag, " DONE cycle"}, done_cyc, v.exp_done);
    check({tag, " DONE pulses"}, done_cnt, 1);
    check({tag, " BUSY cycles"}, busy_cnt, v.exp_done - 1);
    check({tag, " first write cycle"}, first_wr, v.exp_fw);
    check({tag, " COUNT at end"}, COUNT, 0);
    check({tag, " ERR"}, ERR, 0);
    check({tag, " protocol errors"}, proto_err, 0);
    check({tag, " reads"}, rd_log.size(), v.len);
    check({tag, " writes"}, wa_log.size(), v.len);
    for (int i = 0; i < v.len && i < rd_log.size() && i < wa_log.size(); i++) begin
      ea = (v.src & 32'hFFFF_FFFC) + 32'(4 * i);
      check($sformatf("%s rd addr %0d", tag, i), rd_log[i], ea);
      check($sformatf("%s wr data %0d", tag, i), wd_log[i], rdata(ea));
      check($sformatf("%s wr addr %0d", tag, i), wa_log[i],
            (v.dst & 32'hFFFF_FFFC) + 32'(4 * i));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv;
    RES = 1'b0; HLT = 1'b0; START = 1'b0; XDACK = 1'b0; XATAI = '0;
    SRC = '0; DST = '0; LEN = '0;
    cyc = 0; hlt_from = 0; hlt_len = 0; age = 0; no_ack = 0; junk = 0;
    prev_req = 0; prev_ack = 0; rd_wait = 0; wr_wait = 0;

    //           src            dst            len rw ww hf hl rs junk done fw
    vecs[0] = '{32'h0000_0100, 32'h0000_0200, 2, 1, 0, 0, 0, 0, 1'b0, 11, 5};
    vecs[1] = '{32'h0000_0040, 32'h0000_0080, 0, 0, 0, 0, 0, 0, 1'b0, 2, -1};
    vecs[2] = '{32'h0000_0300, 32'h0000_0400, 1, 3, 0, 3, 5, 0, 1'b0, 10, 9};
    vecs[3] = '{32'h0000_0500, 32'h0000_0600, 1, 0, 0, 1, 2, 0, 1'b0, 7, 6};
    vecs[4] = '{32'hFFFF_FFFC, 32'h0000_0010, 2, 0, 2, 0, 0, 3, 1'b1, 13, 4};
    vecs[5] = '{32'h0000_1003, 32'h0000_2002, 3, 2, 1, 0, 0, 0, 1'b0, 22, 6};
    vecs[6] = '{32'h0000_0080, 32'hFFFF_FFF8, 3, 0, 0, 3, 3, 0, 1'b1, 16, 7};

    #3;
    check("reset BUSY", BUSY, 0);
    check("reset DONE", DONE, 0);
    check("reset ERR", ERR, 0);
    check("reset COUNT", COUNT, 0);
    check("reset XDREQ/XRD/XWR", {XDREQ, XRD, XWR}, 0);
    check("reset XBE", XBE, 0);
    check("reset XADDR", XADDR, 0);
    check("reset XATAO", XATAO, 0);
    @(negedge CLK);
    RES = 1'b1;
    @(posedge CLK);
    #1;

    for (int i = 0; i < 7; i++) run_job(vecs[i], $sformatf("vec%0d", i));

    // Reset pulse while a write request is held on the bus.
    tv = '{32'h0000_0900, 32'h0000_0A00, 3, 0, 20, 0, 0, 0, 1'b0, 0, 0};
    begin_job(tv, 1'b0);
    while (!XWR && cyc < 50) step();
    check("pre-reset XWR", XWR, 1);
    check("pre-reset COUNT", COUNT, 3);
    #2;
    RES = 1'b0;
    #1;
    check("async reset XDREQ", XDREQ, 0);
    check("async reset XWR", XWR, 0);
    check("async reset BUSY", BUSY, 0);
    check("async reset COUNT", COUNT, 0);
    check("async reset XADDR", XADDR, 0);
    @(negedge CLK);
    RES = 1'b1;
    XDACK = 1'b0; prev_req = 0; prev_ack = 0;
    @(posedge CLK);
    #1;
    run_job(vecs[0], "after-reset");

`ifdef XBUS_TIMEOUT_EN
    // Responder never acknowledges: request drops after 8 cycles.
    tv = '{32'h0000_0700, 32'h0000_0800, 3, 0, 0, 0, 0, 0, 1'b0, 10, -1};
    begin_job(tv, 1'b1);
    while (done_cyc < 0 && cyc < 40) step();
    check("tmo DONE cycle", done_cyc, 10);
    check("tmo XDREQ cycles", req_cnt, 8);
    check("tmo XDREQ dropped", XDREQ, 0);
    check("tmo ERR", ERR, 1);
    check("tmo COUNT", COUNT, 3);
    check("tmo BUSY", BUSY, 0);
    step(); step(); step();
    check("tmo ERR sticky", ERR, 1);
    check("tmo DONE pulses", done_cnt, 1);
    check("tmo protocol errors", proto_err, 0);
    run_job(vecs[0], "after-tmo");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
